uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one tx_transmitter between NUM_REQ requesters. It accepts requests, captures the winner's payload and packet format, and drives tx_send, tx_data and packet_struct. It tracks the transmitter through one full packet, then pulses a per-requester done. It sits between the register/host side and the transmitter and holds tx_data and packet_struct stable for the whole transaction.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the FSM encoding, packet-struct field positions and helpers.
package uart_pkg;

    localparam int DATA_W    = 16;
    localparam int STRUCT_W  = 8;

    localparam int BITS_LSB  = 0;
    localparam int BITS_MSB  = 3;
    localparam int WORDS_LSB = 5;
    localparam int WORDS_MSB = 7;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LAUNCH = 2'd1,
        ARB_WAIT   = 2'd2,
        ARB_FINISH = 2'd3
    } arb_state_t;

    function automatic logic [2:0] pkt_words(
        input logic [STRUCT_W-1:0] s
    );
        return s[WORDS_MSB:WORDS_LSB];
    endfunction

    function automatic logic [3:0] pkt_bits(
        input logic [STRUCT_W-1:0] s
    );
        return s[BITS_MSB:BITS_LSB];
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above rr_ptr.
// Ports: req, rr_ptr in; winner index and any_valid out.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any_valid
);
    localparam int IW = $clog2(NUM_REQ);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IW:0]          sum;

    // rot[0] is the requester at rr_ptr, rot[1] the next one, and so on
    assign dbl = {req, req};
    assign rot = NUM_REQ'(dbl >> rr_ptr);

    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        sum       = '0;
        // descending scan so the lowest rotated offset wins
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = {1'b0, rr_ptr} + (IW+1)'(i);
                if (sum >= (IW+1)'(NUM_REQ))
                    sum = sum - (IW+1)'(NUM_REQ);
                winner    = sum[IW-1:0];
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// In: req/req_data/req_struct, tx_ready/tx_done. Out: gnt, done, busy,
// owner, word_cnt, tx_send, tx_data, packet_struct. With
// UART_ARB_TIMEOUT_EN: watchdog adds timeout_err and tx_rst outputs.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
`ifdef UART_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ*STRUCT_W-1:0]  req_struct,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           done,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   owner,
    output logic [2:0]                   word_cnt,
    output logic                         tx_send,
    output logic [DATA_W-1:0]            tx_data,
    output logic [STRUCT_W-1:0]          packet_struct,
    input  logic                         tx_ready,
    input  logic                         tx_done
`ifdef UART_ARB_TIMEOUT_EN
    ,
    output logic                         timeout_err,
    output logic                         tx_rst
`endif
);
    localparam int IW = $clog2(NUM_REQ);

    arb_state_t state, state_nxt;

    logic [IW-1:0]       rr_ptr;
    logic [IW-1:0]       win;
    logic                any;
    logic                first;
    logic                tx_done_q;
    logic                capture;
    logic                advance;
    logic                tmo;
    logic [NUM_REQ-1:0]  own_oh;
    logic [DATA_W-1:0]   sel_data;
    logic [STRUCT_W-1:0] sel_struct;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .winner    (win),
        .any_valid (any)
    );

    assign own_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    assign tmo = (state == ARB_LAUNCH || state == ARB_WAIT)
              && tmo_cnt == 16'(TIMEOUT_CYCLES - 1);
    assign timeout_err = tmo;
    assign tx_rst      = tmo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt <= '0;
        else if (capture)
            tmo_cnt <= '0;
        else if (state == ARB_LAUNCH || state == ARB_WAIT)
            tmo_cnt <= tmo_cnt + 16'd1;
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        sel_data   = '0;
        sel_struct = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == IW'(i)) begin
                sel_data   = req_data[i*DATA_W +: DATA_W];
                sel_struct = req_struct[i*STRUCT_W +: STRUCT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ARB_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        advance   = 1'b0;
        gnt       = '0;
        done      = '0;
        tx_send   = 1'b0;
        busy      = (state != ARB_IDLE);
        unique case (state)
            ARB_IDLE: begin
                if (any && tx_ready) begin
                    capture   = 1'b1;
                    state_nxt = ARB_LAUNCH;
                end
            end
            ARB_LAUNCH: begin
                tx_send = 1'b1;
                if (first)
                    gnt = own_oh;
                if (tmo) begin
                    advance   = 1'b1;
                    state_nxt = ARB_IDLE;
                end else if (!tx_ready) begin
                    state_nxt = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (tmo) begin
                    advance   = 1'b1;
                    state_nxt = ARB_IDLE;
                end else if (tx_ready) begin
                    state_nxt = ARB_FINISH;
                end
            end
            ARB_FINISH: begin
                done      = own_oh;
                advance   = 1'b1;
                state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            owner         <= '0;
            word_cnt      <= '0;
            tx_data       <= '0;
            packet_struct <= '0;
            first         <= 1'b0;
            tx_done_q     <= 1'b0;
        end else begin
            tx_done_q <= tx_done;
            first     <= capture;
            if (capture) begin
                owner         <= win;
                word_cnt      <= '0;
                tx_data       <= sel_data;
                packet_struct <= sel_struct;
            end
            // one count per STOP phase the transmitter enters
            if (state == ARB_WAIT && tx_done && !tx_done_q)
                word_cnt <= word_cnt + 3'd1;
            if (advance) begin
                if (owner == IW'(NUM_REQ - 1))
                    rr_ptr <= '0;
                else
                    rr_ptr <= owner + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural transmitter.
// Grants, payloads and word counts are predicted from round-robin rules.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N  = 4;
    localparam int IW = $clog2(N);

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*16-1:0] req_data;
    logic [N*8-1:0]  req_struct;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic            busy;
    logic [IW-1:0]   owner;
    logic [2:0]      word_cnt;
    logic            tx_send;
    logic [15:0]     tx_data;
    logic [7:0]      packet_struct;
    logic            tx_ready;
    logic            tx_done;
    logic            xrst;
`ifdef UART_ARB_TIMEOUT_EN
    logic            timeout_err;
    logic            tx_rst;
    assign xrst = tx_rst;
`else
    assign xrst = 1'b0;
`endif

    uart_tx_arbiter #(
        .NUM_REQ(N)
`ifdef UART_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES(64)
`endif
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .req_data      (req_data),
        .req_struct    (req_struct),
        .gnt           (gnt),
        .done          (done),
        .busy          (busy),
        .owner         (owner),
        .word_cnt      (word_cnt),
        .tx_send       (tx_send),
        .tx_data       (tx_data),
        .packet_struct (packet_struct),
        .tx_ready      (tx_ready),
        .tx_done       (tx_done)
`ifdef UART_ARB_TIMEOUT_EN
        , .timeout_err (timeout_err)
        , .tx_rst      (tx_rst)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
        end
    endtask

    // transmitter: words+1 words, each data phase then a STOP phase
    bit hold  = 0;
    bit stuck = 0;
    int ts, tcnt, twl;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts <= 0; tcnt <= 0; twl <= 0;
            tx_ready <= 1'b1; tx_done <= 1'b0;
        end else if (xrst) begin
            ts <= 0; tx_ready <= 1'b1; tx_done <= 1'b0;
        end else begin
            case (ts)
                0: begin
                    tx_done <= 1'b0;
                    if (tx_send && tx_ready && !hold) begin
                        ts       <= 1;
                        tx_ready <= 1'b0;
                        tcnt     <= $urandom_range(1, 4);
                        twl      <= int'(pkt_words(packet_struct));
                    end else begin
                        tx_ready <= !hold;
                    end
                end
                1: begin
                    if (!stuck) begin
                        if (tcnt == 0) begin
                            ts      <= 2;
                            tx_done <= 1'b1;
                            tcnt    <= $urandom_range(0, 1);
                        end else begin
                            tcnt <= tcnt - 1;
                        end
                    end
                end
                default: begin
                    if (tcnt == 0) begin
                        tx_done <= 1'b0;
                        if (twl == 0) begin
                            ts       <= 0;
                            tx_ready <= 1'b1;
                        end else begin
                            twl  <= twl - 1;
                            ts   <= 1;
                            tcnt <= $urandom_range(1, 4);
                        end
                    end else begin
                        tcnt <= tcnt - 1;
                    end
                end
            endcase
        end
    end

    typedef struct {
        int          who;
        logic [15:0] data;
        logic [7:0]  st;
        logic [2:0]  wc;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   act = 0;
    int   ptr = 0;

    function automatic int pick(input logic [N-1:0] r);
        for (int k = 0; k < N; k++)
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        return 0;
    endfunction

    // monitor
    always @(negedge clk) begin
        logic [N-1:0] oh;
        if (!rst_n) begin
            q.delete();
            act = 0;
        end else begin
            if (gnt != '0) begin
                if (q.size() == 0) begin
                    chk("gnt_unexpected", 32'(gnt), 0);
                end else begin
                    cur = q.pop_front();
                    act = 1;
                    oh = '0;
                    oh[cur.who] = 1'b1;
                    chk("gnt", 32'(gnt), 32'(oh));
                    chk("owner", 32'(owner), 32'(cur.who));
                end
            end
            if (act && busy) begin
                chk("tx_data", 32'(tx_data), 32'(cur.data));
                chk("packet_struct", 32'(packet_struct), 32'(cur.st));
            end
`ifdef UART_ARB_TIMEOUT_EN
            if (timeout_err) act = 0;
`endif
            if (done != '0) begin
                if (!act) begin
                    chk("done_unexpected", 32'(done), 0);
                end else begin
                    oh = '0;
                    oh[cur.who] = 1'b1;
                    chk("done", 32'(done), 32'(oh));
                    chk("word_cnt", 32'(word_cnt), 32'(cur.wc));
                    chk("done_rdy", 32'(tx_ready), 1);
                    act = 0;
                end
            end
        end
    end

    task automatic issue(input logic [N-1:0] r, input bit ov,
                         input logic [15:0] od, input logic [7:0] os);
        exp_t e;
        int   w;
        for (int i = 0; i < N; i++) begin
            req_data[i*16 +: 16]  = 16'($urandom);
            req_struct[i*8 +: 8]  = 8'($urandom);
        end
        w = pick(r);
        if (ov) begin
            req_data[w*16 +: 16] = od;
            req_struct[w*8 +: 8] = os;
        end
        e.who  = w;
        e.data = req_data[w*16 +: 16];
        e.st   = req_struct[w*8 +: 8];
        e.wc   = 3'(pkt_words(e.st) + 3'd1);
        q.push_back(e);
        ptr = (w + 1) % N;
        req = r;
    endtask

    task automatic wait_gnt(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (gnt == '0 && lat < 40);
        if (gnt == '0) chk("gnt_timeout", 0, 1);
        // garbage after capture must not matter
        req        = N'($urandom);
        req_data   = {N{16'($urandom)}};
        req_struct = {N{8'($urandom)}};
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == '0 && n < 400);
        if (done == '0) chk("done_timeout", 0, 1);
        req = '0;
    endtask

    task automatic idle2();
        @(negedge clk);
        @(negedge clk);
    endtask

    int lat;

    initial begin
        rst_n      = 1'b1;
        req        = '0;
        req_data   = '0;
        req_struct = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_word_cnt", 32'(word_cnt), 0);
        chk("rst_tx_send", 32'(tx_send), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_pkt", 32'(packet_struct), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle2();

        // single request
        issue(4'b0010, 1, 16'hA5C3, 8'h07);
        wait_gnt(lat);
        chk("single_lat", lat, 1);
        wait_done();
        idle2();

        // all requests held, back-to-back rotation
        for (int k = 0; k < 8; k++) begin
            issue(4'b1111, 0, 16'h0, 8'h0);
            wait_gnt(lat);
            chk("allreq_lat", lat, (k == 0) ? 1 : 2);
            wait_done();
        end
        idle2();

        // transmitter not ready
        hold = 1;
        idle2();
        issue(4'b0001, 0, 16'h0, 8'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_gnt", 32'(gnt), 0);
            chk("hold_tx_send", 32'(tx_send), 0);
        end
        hold = 0;
        wait_gnt(lat);
        chk("hold_lat", lat, 2);
        wait_done();
        idle2();

        // multi-word
        issue(4'b0100, 1, 16'h1234, 8'h47);
        wait_gnt(lat);
        wait_done();

        // randomized back-to-back traffic
        for (int k = 0; k < 30; k++) begin
            issue(N'($urandom_range(1, (1 << N) - 1)), 0, 16'h0, 8'h0);
            wait_gnt(lat);
            wait_done();
            if ($urandom_range(0, 1) == 1) idle2();
        end
        idle2();

        // reset in the middle of WAIT
        issue(4'b0100, 1, 16'hBEEF, 8'h67);
        wait_gnt(lat);
        begin
            int n = 0;
            while (!(busy && !tx_send) && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("reach_wait", 32'(busy && !tx_send), 1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 0);
        chk("mid_tx_send", 32'(tx_send), 0);
        chk("mid_gnt", 32'(gnt), 0);
        chk("mid_done", 32'(done), 0);
        chk("mid_tx_data", 32'(tx_data), 0);
        chk("mid_word_cnt", 32'(word_cnt), 0);
        req = '0;
        ptr = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(4'b1001, 0, 16'h0, 8'h0);
        wait_gnt(lat);
        chk("post_rst_lat", lat, 1);
        wait_done();
        idle2();

`ifdef UART_ARB_TIMEOUT_EN
        stuck = 1;
        issue(4'b0100, 0, 16'h0, 8'h0);
        wait_gnt(lat);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
                if (done != '0) chk("tmo_no_done", 32'(done), 0);
            end while (!timeout_err && n < 200);
            chk("tmo_lat", n, 63);
            chk("tmo_tx_rst", 32'(tx_rst), 1);
        end
        stuck = 0;
        req = '0;
        issue(4'b1100, 0, 16'h0, 8'h0);
        wait_gnt(lat);
        chk("tmo_next_owner", 32'(owner), 3);
        wait_done();
        idle2();
`endif

        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
